uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL provide parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 The block SHALL provide parameter OVERSAMPLE, default 16, number of sample_tick pulses per bit period.
REQ-003 Port sys_clk SHALL be input, 1 bit: single system clock; all logic on rising edge.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sample_tick SHALL be input, 1 bit: one-cycle enable from the baud generator, OVERSAMPLE per bit.
REQ-006 Port rx SHALL be input, 1 bit: asynchronous serial line, idle high.
REQ-007 Port rx_data SHALL be output, DATA_BITS wide: last received byte, LSB first on the line.
REQ-008 Port rx_valid SHALL be output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-009 Port frame_err SHALL be output, 1 bit: one-cycle pulse when stop bit samples low.
REQ-010 Port busy SHALL be output, 1 bit: high whenever FSM is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; 2-cycle input latency.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: synchronized rx low on a sample_tick -> START, tick counter cleared.
REQ-014 START: at tick count OVERSAMPLE/2-1 (mid-bit), rx low -> DATA with counters cleared; rx high -> IDLE (glitch rejected, no output).
REQ-015 Tick counter SHALL advance only on sample_tick; sampling at count OVERSAMPLE-1 thereafter (mid-bit).
REQ-016 DATA: each mid-bit sample SHALL shift into MSB of shift register (LSB-first); after DATA_BITS samples -> PARITY or STOP.
REQ-017 STOP: mid-bit sample high -> rx_data loaded, rx_valid pulse, IDLE.
REQ-018 STOP: mid-bit sample low -> frame_err pulse, rx_data unchanged, no rx_valid; FSM waits in IDLE only after rx returns high (break condition does not restart reception).
REQ-019 rx_valid and frame_err SHALL never assert in the same cycle and SHALL be exactly one sys_clk wide.
REQ-020 Back-to-back frames (next start bit immediately after stop mid-sample) SHALL be received without loss.
REQ-021 sample_tick absent SHALL freeze the FSM and counters.

Reset
REQ-022 On rst low: FSM IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, busy 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no output pulse.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, PARITY state SHALL sample one even-parity bit after DATA; mismatch SHALL pulse parity_err (extra 1-bit output) and suppress rx_valid for that frame.
REQ-025 Without UART_RX_PARITY_EN, PARITY state and parity_err port SHALL not exist; DATA proceeds directly to STOP.

Structure
REQ-026 Package uart_pkg SHALL hold the rx state enum typedef and default OVERSAMPLE/DATA_BITS constants.
REQ-027 The synchronizer SHALL be a sub-module named uart_sync2 (2-flop, reset value 1).
REQ-028 Counters SHALL be sized $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1); no wrap beyond terminal count.

Verification
REQ-029 Frame 0x55, valid stop, sample_tick every 4 clocks -> rx_data=0x55, one rx_valid pulse, frame_err 0.
REQ-030 Start-bit glitch low for 3 ticks -> FSM returns IDLE, no rx_valid, busy drops.
REQ-031 Frame 0xA3 with stop bit driven low -> frame_err pulse, rx_data keeps prior 0x55.
REQ-032 Back-to-back 0x00 then 0xFF -> two rx_valid pulses, values in order.
REQ-033 rst low at DATA bit 4 of 0x3C, then full frame 0x81 -> no output for 0x3C, rx_data=0x81.
REQ-034 Macro defined, 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_valid, rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: data, strobes and status.
// parity_err only exists when UART_RX_PARITY_EN is defined.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
`ifdef UART_RX_PARITY_EN
        input parity_err,
`endif
        input busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle line looks idle.
module uart_sync2 (
    input  logic sys_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN for an even-parity bit and parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic      sys_clk,
    input  logic      rst,
    input  logic      sample_tick,
    input  logic      rx,
    uart_rx_if.master rx_if
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] NB_M1 = BW'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bitc, bitc_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data, data_n;
    logic                 valid, valid_n;
    logic                 ferr, ferr_n;
    logic                 brk, brk_n;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 perr, perr_n;
    logic                 pbad, pbad_n;
`endif

    uart_sync2 u_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitc  <= '0;
            shift <= '0;
            data  <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
            brk   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr  <= 1'b0;
            pbad  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitc  <= bitc_n;
            shift <= shift_n;
            data  <= data_n;
            valid <= valid_n;
            ferr  <= ferr_n;
            brk   <= brk_n;
`ifdef UART_RX_PARITY_EN
            perr  <= perr_n;
            pbad  <= pbad_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitc_n  = bitc;
        shift_n = shift;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        brk_n   = brk & ~rx_s;
`ifdef UART_RX_PARITY_EN
        perr_n  = 1'b0;
        pbad_n  = pbad;
`endif
        if (sample_tick) begin
            unique case (state)
                // A line held low after a bad stop bit is a break, not a start.
                IDLE: begin
                    if (!rx_s && !brk) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    if (cnt == MID) begin
                        cnt_n   = '0;
                        bitc_n  = '0;
                        state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                        pbad_n  = 1'b0;
`endif
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        bitc_n  = bitc + 1'b1;
                        if (bitc == NB_M1) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        state_n = STOP;
                        if ((^shift) != rx_s) begin
                            perr_n = 1'b1;
                            pbad_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        if (!rx_s) begin
                            ferr_n = 1'b1;
                            brk_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (!pbad) begin
`else
                        end else begin
`endif
                            data_n  = shift;
                            valid_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign rx_if.rx_data   = data;
    assign rx_if.rx_valid  = valid;
    assign rx_if.frame_err = ferr;
    assign rx_if.busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frame bench for uart_rx with a frame-level model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int TPB = 4;
    localparam int BIT = OS * TPB;

    logic sys_clk = 1'b0;
    logic rst = 1'b0;
    logic sample_tick = 1'b0;
    logic rx = 1'b1;
    int   tdiv = 0;

    int passes = 0;
    int total = 0;
    int vcnt = 0, fcnt = 0, pcnt = 0, both = 0, wide = 0;
    int ev = 0, ef = 0, ep = 0;
    logic pv = 1'b0, pf = 1'b0;
    logic [7:0] last = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_if #(.DATA_BITS(DB)) rif ();

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_if       (rif)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        tdiv        <= (tdiv == TPB - 1) ? 0 : tdiv + 1;
        sample_tick <= (tdiv == TPB - 1);
    end

    always @(negedge sys_clk) begin
        if (rst) begin
            if (rif.rx_valid) begin
                vcnt++;
                got_q.push_back(rif.rx_data);
            end
            if (rif.frame_err) fcnt++;
`ifdef UART_RX_PARITY_EN
            if (rif.parity_err) pcnt++;
`endif
            if (rif.rx_valid && rif.frame_err) both++;
            if ((rif.rx_valid && pv) || (rif.frame_err && pf)) wide++;
            pv = rif.rx_valid;
            pf = rif.frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1);
        repeat (n - 1) send_bit(1'b1);
    endtask

    // Frame-level expectation from the line contents alone.
    task automatic model(input logic [7:0] d, input logic stop,
                         input logic par);
        logic pok;
        pok = 1'b1;
`ifdef UART_RX_PARITY_EN
        pok = ((^d) == par);
        if (!pok) ep++;
`endif
        if (!stop) ef++;
        else if (pok) begin
            ev++;
            exp_q.push_back(d);
            last = d;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        model(d, stop, par);
    endtask

    task automatic drain(input string tag);
        logic [7:0] g, e;
        check({tag, "_nvalid"}, vcnt, ev);
        check({tag, "_nferr"}, fcnt, ef);
`ifdef UART_RX_PARITY_EN
        check({tag, "_nperr"}, pcnt, ep);
`endif
        check({tag, "_qsize"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_rx_data"}, rif.rx_data, last);
    endtask

    initial begin
        logic [7:0] d;
        logic       s, p;

        repeat (5) @(negedge sys_clk);
        check("rst_rx_data", rif.rx_data, 0);
        check("rst_valid", rif.rx_valid, 0);
        check("rst_ferr", rif.frame_err, 0);
        check("rst_busy", rif.busy, 0);
        rst = 1'b1;
        idle(2);

        send_frame(8'h55, 1'b1, ^8'h55);
        idle(1);
        drain("f55");

        rx = 1'b0;
        repeat (3 * TPB) @(negedge sys_clk);
        check("glitch_busy_hi", rif.busy, 1);
        rx = 1'b1;
        idle(1);
        check("glitch_busy_lo", rif.busy, 0);
        drain("glitch");

        send_frame(8'hA3, 1'b0, ^8'hA3);
        idle(1);
        drain("fA3");

        send_frame(8'h12, 1'b0, ^8'h12);
        send_bit(1'b0);
        check("break_busy", rif.busy, 0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("break_busy2", rif.busy, 0);
        idle(1);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(1);
        drain("break");

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(1);
        drain("b2b");

        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (BIT / 2) @(negedge sys_clk);
        check("mid_busy", rif.busy, 1);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        rx = 1'b1;
        check("mrst_busy", rif.busy, 0);
        check("mrst_data", rif.rx_data, 0);
        rst = 1'b1;
        last = 8'h00;
        idle(6);
        drain("mrst");
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(1);
        drain("f81");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(1);
        drain("par_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        idle(1);
        drain("par_ok");
`endif

        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            p = ^d;
            if ($urandom_range(0, 3) == 0) p = ~p;
            send_frame(d, s, p);
            idle(1);
            drain("rand");
        end

        check("valid_and_ferr", both, 0);
        check("pulse_width", wide, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
